// File: rtl/spsram_banked_pkg.sv
// Shared types and helpers for the banked scratch SRAM.
// Holds the FSM state encoding and a constant-foldable clog2.
package spsram_banked_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/spsram_banked_if.sv
// Request/response bundle of the banked scratch SRAM.
// Signal names are seen from the memory side.
interface spsram_banked_if #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 6
);
  localparam int BW_BE = BW_DATA / 8;

  logic               i_req;
  logic               i_wen;
  logic [BW_ADDR-1:0] i_addr;
  logic [BW_DATA-1:0] i_data;
  logic [BW_BE-1:0]   i_be;
  logic               o_ready;
  logic               o_rvalid;
  logic [BW_DATA-1:0] o_data;

  modport master (
    output i_req, i_wen, i_addr,
    output i_data, i_be,
    input  o_ready, o_rvalid, o_data
  );

  modport slave (
    input  i_req, i_wen, i_addr,
    input  i_data, i_be,
    output o_ready, o_rvalid, o_data
  );

endinterface

// File: rtl/spsram_bank.sv
// One SRAM bank: byte-enabled write, registered read.
// The read register only moves on a read, so it holds between reads.
module spsram_bank #(
  parameter int BW_DATA  = 32,
  parameter int BW_LADDR = 4
) (
  input  logic                i_clk,
  input  logic                i_cen,
  input  logic                i_wen,
  input  logic [BW_DATA/8-1:0] i_be,
  input  logic [BW_LADDR-1:0] i_addr,
  input  logic [BW_DATA-1:0]  i_data,
  output logic [BW_DATA-1:0]  o_data
);
  localparam int BW_BE = BW_DATA / 8;

  logic [BW_DATA-1:0] mem [2**BW_LADDR];

  always_ff @(posedge i_clk) begin
    if (i_cen) begin
      if (i_wen) begin
        for (int k = 0; k < BW_BE; k++) begin
          if (i_be[k]) mem[i_addr][8*k +: 8] <= i_data[8*k +: 8];
        end
      end else begin
        o_data <= mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/spsram_banked.sv
// Banked single-port scratch SRAM with post-reset zero-fill.
// Upper address bits pick the bank; reads return one cycle later.
module spsram_banked
  import spsram_banked_pkg::*;
#(
  parameter int BW_DATA  = 32,
  parameter int BW_ADDR  = 6,
  parameter int NUM_BANK = 4
) (
  input logic          i_clk,
  input logic          i_rstn,
  spsram_banked_if.slave bus
);
  localparam int BW_BANK  = clog2(NUM_BANK);
  localparam int BW_LADDR = BW_ADDR - BW_BANK;
  localparam int BW_BE    = BW_DATA / 8;

  state_t              state, state_nxt;
  logic [BW_LADDR-1:0] clr_cnt, clr_cnt_nxt;
  logic [BW_BANK-1:0]  bank_sel, sel_q;
  logic                clearing, acc, rd;
  logic                rvalid, rd_seen;

  logic                b_wen;
  logic [BW_BE-1:0]    b_be;
  logic [BW_LADDR-1:0] b_addr;
  logic [BW_DATA-1:0]  b_data;
  logic [BW_DATA-1:0]  rdata [NUM_BANK];

  assign clearing = (state == ST_CLEAR);
  assign acc      = bus.i_req & ~clearing;
  assign rd       = acc & ~bus.i_wen;
  assign bank_sel = bus.i_addr[BW_ADDR-1 -: BW_BANK];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    unique case (state)
      ST_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == '1) state_nxt = ST_READY;
      end
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // Zero-fill overrides the request path in every bank at once.
  always_comb begin
    b_wen  = bus.i_wen;
    b_be   = bus.i_be;
    b_addr = bus.i_addr[BW_LADDR-1:0];
    b_data = bus.i_data;
    if (clearing) begin
      b_wen  = 1'b1;
      b_be   = '1;
      b_addr = clr_cnt;
      b_data = '0;
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic cen;
    assign cen = clearing |
                 (acc & (bank_sel == BW_BANK'(b)));

    spsram_bank #(
      .BW_DATA  (BW_DATA),
      .BW_LADDR (BW_LADDR)
    ) u_bank (
      .i_clk  (i_clk),
      .i_cen  (cen),
      .i_wen  (b_wen),
      .i_be   (b_be),
      .i_addr (b_addr),
      .i_data (b_data),
      .o_data (rdata[b])
    );
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rvalid  <= 1'b0;
      rd_seen <= 1'b0;
      sel_q   <= '0;
    end else begin
      rvalid <= rd;
      if (rd) begin
        rd_seen <= 1'b1;
        sel_q   <= bank_sel;
      end
    end
  end

  // Bank read registers are not reset, so mask until a read lands.
  assign bus.o_data   = rd_seen ? rdata[sel_q] : '0;
  assign bus.o_rvalid = rvalid;
  assign bus.o_ready  = ~clearing;

endmodule
